// File: rtl/square_reconstructor.sv
// ---------------------------------------------------------------------------
// square_reconstructor
//   Rebuilds a radicand from a (root, remainder) pair as root*root + remainder
//   with an iterative shift-add multiplier that consumes one root bit per
//   clock. It sits downstream of square_extractor, so the sqrt datapath can
//   be checked end to end.
//
// Optional feature macro: SQUARE_RECON_CHECK_EN
//   When defined, the block samples the original radicand on the input
//   handshake. It then flags a registered mismatch together with the result.
//
// Parameters
//   WIDTH       root width (>= 2); the result is 2*WIDTH bits
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   din_valid   root/remainder valid
//   din_ready   block can accept (IDLE only, low while rst is high)
//   root        square root, WIDTH bits
//   remainder   remainder, WIDTH+1 bits (legal range 0..2*root)
//   dout_valid  result valid, held until dout_ready
//   dout_ready  downstream accepts the result
//   dout        root*root + remainder, mod 2**(2*WIDTH)
//   rem_err     remainder > 2*root for the transaction in flight
//   expected    (CHECK_EN) original radicand, sampled on accept
//   mismatch    (CHECK_EN) (dout != expected) | rem_err, valid with dout_valid
// ---------------------------------------------------------------------------
module square_reconstructor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [WIDTH-1:0]     root,
    input  logic [WIDTH:0]       remainder,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [2*WIDTH-1:0]   dout,
`ifdef SQUARE_RECON_CHECK_EN
    input  logic [2*WIDTH-1:0]   expected,
    output logic                 mismatch,
`endif
    output logic                 rem_err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q,   state_d;
    logic [2*WIDTH-1:0]     acc_q,     acc_d;
    logic [WIDTH-1:0]       mcand_q,   mcand_d;
    logic [WIDTH-1:0]       mplier_q,  mplier_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic                   rem_err_q, rem_err_d;
`ifdef SQUARE_RECON_CHECK_EN
    logic [2*WIDTH-1:0]     expected_q, expected_d;
    logic                   mismatch_q, mismatch_d;
`endif

    // din_ready is gated by rst so that upstream sees "not ready" for the
    // whole reset window, including the first reset cycle.
    assign din_ready  = (state_q == S_IDLE) && !rst;
    assign dout_valid = (state_q == S_DONE);
    assign dout       = acc_q;
    assign rem_err    = rem_err_q;
`ifdef SQUARE_RECON_CHECK_EN
    assign mismatch   = mismatch_q;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        rem_err_d = rem_err_q;
`ifdef SQUARE_RECON_CHECK_EN
        expected_d = expected_q;
        mismatch_d = mismatch_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    // The accumulator is seeded with the remainder, so the
                    // multiply loop only has to add the partial products.
                    acc_d     = {{(WIDTH-1){1'b0}}, remainder};
                    mcand_d   = root;
                    mplier_d  = root;
                    cnt_d     = '0;
                    rem_err_d = (remainder > {root, 1'b0});
                    state_d   = S_CALC;
`ifdef SQUARE_RECON_CHECK_EN
                    expected_d = expected;
                    mismatch_d = 1'b0;
`endif
                end
            end
            S_CALC: begin
                if (mplier_q[cnt_q])
                    acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
`ifdef SQUARE_RECON_CHECK_EN
                    // Uses the final accumulator value so that the flag
                    // lands on the same edge as dout_valid.
                    mismatch_d = (acc_d != expected_q) | rem_err_q;
`endif
                end
            end
            S_DONE: begin
                if (dout_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            rem_err_q <= 1'b0;
`ifdef SQUARE_RECON_CHECK_EN
            expected_q <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            rem_err_q <= rem_err_d;
`ifdef SQUARE_RECON_CHECK_EN
            expected_q <= expected_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

endmodule

// File: tb/tb_square_reconstructor.sv
module tb_square_reconstructor;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           din_valid = 1'b0;
    logic           din_ready;
    logic [W-1:0]   root = '0;
    logic [W:0]     remainder = '0;
    logic           dout_valid;
    logic           dout_ready = 1'b0;
    logic [2*W-1:0] dout;
    logic           rem_err;
`ifdef SQUARE_RECON_CHECK_EN
    logic [2*W-1:0] expected = '0;
    logic           mismatch;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    square_reconstructor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .root       (root),
        .remainder  (remainder),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
`ifdef SQUARE_RECON_CHECK_EN
        .expected   (expected),
        .mismatch   (mismatch),
`endif
        .rem_err    (rem_err)
    );

    always #5 clk = ~clk;

    // Reference model: the arithmetic definition, no notion of cycles.
    function automatic logic [2*W-1:0] model_sq(input int r, input int m);
        return (2*W)'((r * r + m) % (1 << (2*W)));
    endfunction

    function automatic logic model_err(input int r, input int m);
        return m > 2 * r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a transaction and waits for the accepting edge. Afterwards the
    // input buses are scrambled, so any late sampling shows up as a bad result.
    task automatic accept(input int r, input int m, input int ex);
        int i;
        root      = W'(r);
        remainder = (W+1)'(m);
`ifdef SQUARE_RECON_CHECK_EN
        expected  = (2*W)'(ex);
`endif
        din_valid = 1'b1;
        i = 0;
        while (!din_ready && i < 50) begin
            step();
            i++;
        end
        n_checks++;
        if (!din_ready) begin
            $display("FAIL accept_timeout: din_ready=%0b required 1", din_ready);
            n_fail++;
        end
        step();
        din_valid = 1'b0;
        root      = W'($urandom);
        remainder = (W+1)'($urandom);
`ifdef SQUARE_RECON_CHECK_EN
        expected  = (2*W)'($urandom);
`endif
        if (ex < 0) begin end
    endtask

    // Counts edges from the accepting edge until dout_valid is seen.
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!dout_valid && edges < 40) begin
            step();
            edges++;
        end
    endtask

    task automatic consume();
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (din_ready !== 1'b0 || dout_valid !== 1'b0 || dout !== '0 || rem_err !== 1'b0) begin
            $display("FAIL reset_state: rdy=%0b vld=%0b dout=%0d err=%0b required 0 0 0 0",
                     din_ready, dout_valid, dout, rem_err);
            n_fail++;
        end
`ifdef SQUARE_RECON_CHECK_EN
        n_checks++;
        if (mismatch !== 1'b0) begin
            $display("FAIL reset_mismatch: got %0b required 0", mismatch);
            n_fail++;
        end
`endif
        rst = 1'b0;
        step();
        n_checks++;
        if (din_ready !== 1'b1) begin
            $display("FAIL reset_release_ready: got %0b required 1", din_ready);
            n_fail++;
        end
    endtask

    task automatic test_basic(input string name, input int r, input int m, input int ex);
        int edges;
        accept(r, m, ex);
        wait_valid(edges);
        n_checks++;
        if (edges !== W) begin
            $display("FAIL %s_latency: got %0d edges required %0d", name, edges, W);
            n_fail++;
        end
        n_checks++;
        if (dout !== model_sq(r, m) || rem_err !== model_err(r, m)) begin
            $display("FAIL %s_result: dout=%0d err=%0b required %0d %0b",
                     name, dout, rem_err, model_sq(r, m), model_err(r, m));
            n_fail++;
        end
`ifdef SQUARE_RECON_CHECK_EN
        n_checks++;
        if (mismatch !== ((model_sq(r, m) != (2*W)'(ex)) || model_err(r, m))) begin
            $display("FAIL %s_mismatch: got %0b required %0b", name, mismatch,
                     (model_sq(r, m) != (2*W)'(ex)) || model_err(r, m));
            n_fail++;
        end
`endif
        consume();
        n_checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            $display("FAIL %s_consume: vld=%0b rdy=%0b required 0 1", name, dout_valid, din_ready);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        int edges;
        accept(5, 3, 28);
        wait_valid(edges);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (dout_valid !== 1'b1 || dout !== 8'd28 || rem_err !== 1'b0 || din_ready !== 1'b0) begin
                $display("FAIL hold_cycle%0d: vld=%0b dout=%0d err=%0b rdy=%0b required 1 28 0 0",
                         i, dout_valid, dout, rem_err, din_ready);
                n_fail++;
            end
            step();
        end
        consume();
        n_checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            $display("FAIL hold_release: vld=%0b rdy=%0b required 0 1", dout_valid, din_ready);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        accept(7, 0, 49);
        step();
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (dout_valid !== 1'b0 || dout !== '0 || rem_err !== 1'b0) begin
            $display("FAIL midreset_state: vld=%0b dout=%0d err=%0b required 0 0 0",
                     dout_valid, dout, rem_err);
            n_fail++;
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (din_ready !== 1'b1) begin
            $display("FAIL midreset_ready: got %0b required 1", din_ready);
            n_fail++;
        end
        test_basic("after_midreset", 9, 0, 81);
    endtask

    task automatic test_sweep();
        int q_r[$];
        int q_m[$];
        int edges, r, m, gap;
        for (r = 0; r < (1 << W); r++) begin
            for (m = 0; m <= 2 * r; m++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step();
                accept(r, m, r * r + m);
                q_r.push_back(r);
                q_m.push_back(m);
                wait_valid(edges);
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) step();
                n_checks++;
                if (!dout_valid || dout !== model_sq(q_r[0], q_m[0]) || rem_err !== 1'b0) begin
                    $display("FAIL sweep r=%0d m=%0d: vld=%0b dout=%0d err=%0b required 1 %0d 0",
                             q_r[0], q_m[0], dout_valid, dout, rem_err, model_sq(q_r[0], q_m[0]));
                    n_fail++;
                end
`ifdef SQUARE_RECON_CHECK_EN
                n_checks++;
                if (mismatch !== 1'b0) begin
                    $display("FAIL sweep_mismatch r=%0d m=%0d: got %0b required 0",
                             q_r[0], q_m[0], mismatch);
                    n_fail++;
                end
`endif
                void'(q_r.pop_front());
                void'(q_m.pop_front());
                consume();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic("zero", 0, 0, 0);
        test_basic("max", 15, 30, 255);
        test_basic("five", 5, 3, 28);
        test_basic("illegal", 3, 7, 16);
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
